serial_to_parallel: RTL and testbench



---
 rtl/serial_to_parallel.sv | 43 ++++
 tb/tb_serial_to_parallel.sv | 85 ++++++++
 2 files changed

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: assembles an LSB-first serial stream into an 8-bit word with a one-cycle done pulse.
module serial_to_parallel (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_start,
  input  logic [0:0] d,
  output logic [7:0] a,
  output logic       end_conversion
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t     state_q;
  logic [2:0] cnt_q;
  logic [6:0] shift_q;
  // Bits enter at the top and move down, so after seven captures bit 0 sits at shift_q[0].
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 3'd0;
      shift_q        <= 7'd0;
      a              <= 8'h00;
      end_conversion <= 1'b0;
    end else begin
      end_conversion <= 1'b0;
      case (state_q)
        IDLE: if (serial_start) begin
          shift_q <= {d, 6'd0};
          cnt_q   <= 3'd1;
          state_q <= SHIFT;
        end
        SHIFT: if (cnt_q == 3'd7) begin
          a              <= {d, shift_q};
          end_conversion <= 1'b1;
          cnt_q          <= 3'd0;
          state_q        <= IDLE;
        end else begin
          shift_q <= {d, shift_q[6:1]};
          cnt_q   <= cnt_q + 3'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_to_parallel.sv
// tb_serial_to_parallel: directed checks of reset, single, back-to-back, restart-ignore, abort and extreme words.
module tb_serial_to_parallel;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_start = 1'b0;
  logic [0:0] d = 1'b0;
  logic [7:0] a;
  logic       end_conversion;
  int         tests = 0;
  int         fails = 0;
  serial_to_parallel dut (
    .clk(clk), .reset(reset), .serial_start(serial_start), .d(d),
    .a(a), .end_conversion(end_conversion)
  );
  always #5 clk = ~clk;
  task automatic tick(input logic s, input logic b);
    serial_start = s;
    d = b;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] ea, input logic ee);
    tests++;
    assert ({a, end_conversion} === {ea, ee})
    else begin
      fails++;
      $error("FAIL %s: got a=%h ec=%b, expected a=%h ec=%b", tag, a, end_conversion, ea, ee);
    end
  endtask
  // Serializes v starting at E0; sm marks bit slots where serial_start is also held high.
  task automatic send(input string tag, input logic [7:0] v, input logic [7:0] prev, input logic [7:0] sm);
    for (int k = 0; k < 8; k++) begin
      tick(k == 0 || sm[k], v[k]);
      if (k < 7) chk(tag, prev, 1'b0);
      else chk(tag, v, 1'b1);
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      chk("reset_hold", 8'h00, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'(i & 1));
      chk("idle_toggle", 8'h00, 1'b0);
    end
    send("basic_4d", 8'h4D, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      chk("trail_4d", 8'h4D, 1'b0);
    end
    send("b2b_a5", 8'hA5, 8'h4D, 8'h00);
    send("b2b_3c", 8'h3C, 8'hA5, 8'h00);
    tick(1'b0, 1'b1);
    chk("after_3c", 8'h3C, 1'b0);
    send("restart_f0", 8'hF0, 8'h3C, 8'b0000_1000);
    tick(1'b0, 1'b0);
    chk("after_f0", 8'hF0, 1'b0);
    send("pre_ff", 8'hFF, 8'hF0, 8'h00);
    tick(1'b0, 1'b0);
    chk("hold_ff", 8'hFF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick(k == 0, 1'b0);
      chk("abort_pre", 8'hFF, 1'b0);
    end
    reset = 1'b1;
    tick(1'b0, 1'b0);
    chk("abort_rst", 8'h00, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1);
      chk("abort_nopulse", 8'h00, 1'b0);
    end
    send("fresh_81", 8'h81, 8'h00, 8'h00);
    send("ext_00", 8'h00, 8'h81, 8'h00);
    send("ext_ff", 8'hFF, 8'h00, 8'h00);
    send("held_5a", 8'h5A, 8'hFF, 8'hFF);
    send("held_c3", 8'hC3, 8'h5A, 8'hFF);
    tick(1'b0, 1'b0);
    chk("final", 8'hC3, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
